// File: rtl/uram_tdp_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// uram_tdp_rr_arbiter_if
// Client-side bundle of the true-dual-port ultraRAM arbiter.
//   req       : request valid per requester, held until granted
//   reqWr     : 1 = write, 0 = read, per requester
//   reqAddrs  : word address, requester i at [i*ADDRS_WIDTH +: ADDRS_WIDTH]
//   reqWrdata : write data, requester i at [i*64 +: 64]
//   gnt       : same-cycle grant per requester
//   rspValid  : read data valid per requester (cycle after the read grant)
//   rspData   : read data per requester, zero when its rspValid bit is low
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface uram_tdp_rr_arbiter_if #(
  parameter int ADDRS_WIDTH = 12,
  parameter int NREQ        = 4
);
  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             reqWr;
  logic [NREQ*ADDRS_WIDTH-1:0] reqAddrs;
  logic [NREQ*64-1:0]          reqWrdata;
  logic [NREQ-1:0]             gnt;
  logic [NREQ-1:0]             rspValid;
  logic [NREQ*64-1:0]          rspData;

  modport master (
    output req, reqWr, reqAddrs, reqWrdata,
    input  gnt, rspValid, rspData
  );

  modport slave (
    input  req, reqWr, reqAddrs, reqWrdata,
    output gnt, rspValid, rspData
  );
endinterface

// File: rtl/uram_tdp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// uram_tdp_rr_arbiter
// Shares one 64-bit true-dual-port ultraRAM between NREQ (=4) requesters.
// Up to two grants per cycle (one per RAM port) in round-robin order, with
// same-address write hazards between the two ports blocked, and read data
// routed back to the requester that issued the read one cycle later.
// Ports:
//   CLK, RESET          : clock, synchronous active-high reset
//   cli (slave)         : requester bundle, see uram_tdp_rr_arbiter_if
//   wrenA/rdenA/...B    : RAM port enables
//   wraddrsA/rdaddrsA/..: RAM port addresses
//   wrdataA/wrdataB     : RAM write data
//   rddataA/rddataB     : RAM read data, valid the cycle after rden
// ---------------------------------------------------------------------------
module uram_tdp_rr_arbiter #(
  parameter int ADDRS_WIDTH = 12,
  parameter int NREQ        = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  uram_tdp_rr_arbiter_if.slave   cli,
  output logic                   wrenA,
  output logic                   rdenA,
  output logic                   wrenB,
  output logic                   rdenB,
  output logic [ADDRS_WIDTH-1:0] wraddrsA,
  output logic [ADDRS_WIDTH-1:0] rdaddrsA,
  output logic [ADDRS_WIDTH-1:0] wraddrsB,
  output logic [ADDRS_WIDTH-1:0] rdaddrsB,
  output logic [63:0]            wrdataA,
  output logic [63:0]            wrdataB,
  input  logic [63:0]            rddataA,
  input  logic [63:0]            rddataB
);

  // Round-robin pointer and per-port read tags {valid, requester index}.
  logic [1:0]             ptr_q, ptr_d;
  logic [2:0]             tag_a_q, tag_a_d;
  logic [2:0]             tag_b_q, tag_b_d;

  logic                   a_found_s;
  logic [1:0]             a_idx_s;
  logic [1:0]             a_cand_s;
  logic                   a_wr_s;
  logic [ADDRS_WIDTH-1:0] a_addr_s;
  logic [63:0]            a_data_s;

  logic                   b_found_s;
  logic [1:0]             b_idx_s;
  logic [1:0]             b_cand_s;
  logic                   b_wr_s;
  logic [ADDRS_WIDTH-1:0] b_addr_s;
  logic [ADDRS_WIDTH-1:0] b_cand_addr_s;
  logic [63:0]            b_data_s;
  logic                   b_conflict_s;

  logic [NREQ-1:0]        gnt_s;
  logic [NREQ-1:0]        rsp_valid_s;
  logic [NREQ*64-1:0]     rsp_data_s;

  // Port A pick: first requesting index scanning circularly from ptr.
  // Nothing is picked while RESET is high, so pending requests simply wait.
  always_comb begin
    a_found_s = 1'b0;
    a_idx_s   = 2'd0;
    a_cand_s  = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      a_cand_s = ptr_q + 2'(k);
      if (!a_found_s && cli.req[a_cand_s] && !RESET) begin
        a_found_s = 1'b1;
        a_idx_s   = a_cand_s;
      end else begin
        a_found_s = a_found_s;
      end
    end
    a_wr_s   = cli.reqWr[a_idx_s];
    a_addr_s = cli.reqAddrs[int'(a_idx_s)*ADDRS_WIDTH +: ADDRS_WIDTH];
    a_data_s = cli.reqWrdata[int'(a_idx_s)*64 +: 64];
  end

  // Port B pick: scan from A+1, skipping requesters that would touch A's
  // address with at least one side writing (read+read is allowed).
  always_comb begin
    b_found_s     = 1'b0;
    b_idx_s       = 2'd0;
    b_cand_s      = 2'd0;
    b_cand_addr_s = '0;
    b_conflict_s  = 1'b0;
    for (int k = 1; k < NREQ; k++) begin
      b_cand_s      = a_idx_s + 2'(k);
      b_cand_addr_s = cli.reqAddrs[int'(b_cand_s)*ADDRS_WIDTH +: ADDRS_WIDTH];
      b_conflict_s  = (b_cand_addr_s == a_addr_s) && (cli.reqWr[b_cand_s] || a_wr_s);
      if (a_found_s && !b_found_s && cli.req[b_cand_s] && !b_conflict_s) begin
        b_found_s = 1'b1;
        b_idx_s   = b_cand_s;
      end else begin
        b_found_s = b_found_s;
      end
    end
    b_wr_s   = cli.reqWr[b_idx_s];
    b_addr_s = cli.reqAddrs[int'(b_idx_s)*ADDRS_WIDTH +: ADDRS_WIDTH];
    b_data_s = cli.reqWrdata[int'(b_idx_s)*64 +: 64];
  end

  // Grants and RAM port drive; an unused port is driven all-zero.
  always_comb begin
    gnt_s = '0;
    if (a_found_s) begin
      gnt_s[a_idx_s] = 1'b1;
    end else begin
      gnt_s = gnt_s;
    end
    if (b_found_s) begin
      gnt_s[b_idx_s] = 1'b1;
    end else begin
      gnt_s = gnt_s;
    end
    wrenA    = a_found_s & a_wr_s;
    rdenA    = a_found_s & ~a_wr_s;
    wraddrsA = a_found_s ? a_addr_s : '0;
    rdaddrsA = a_found_s ? a_addr_s : '0;
    wrdataA  = a_found_s ? a_data_s : 64'd0;
    wrenB    = b_found_s & b_wr_s;
    rdenB    = b_found_s & ~b_wr_s;
    wraddrsB = b_found_s ? b_addr_s : '0;
    rdaddrsB = b_found_s ? b_addr_s : '0;
    wrdataB  = b_found_s ? b_data_s : 64'd0;
  end

  // Next state: pointer moves past the last winner; tags remember reads.
  always_comb begin
    if (b_found_s) begin
      ptr_d = b_idx_s + 2'd1;
    end else if (a_found_s) begin
      ptr_d = a_idx_s + 2'd1;
    end else begin
      ptr_d = ptr_q;
    end
    tag_a_d = {a_found_s & ~a_wr_s, a_idx_s};
    tag_b_d = {b_found_s & ~b_wr_s, b_idx_s};
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q   <= 2'd0;
      tag_a_q <= 3'd0;
      tag_b_q <= 3'd0;
    end else begin
      ptr_q   <= ptr_d;
      tag_a_q <= tag_a_d;
      tag_b_q <= tag_b_d;
    end
  end

  // Read return: decode the registered tags. RESET in the return cycle
  // drops the response immediately rather than one edge later.
  always_comb begin
    rsp_valid_s = '0;
    rsp_data_s  = '0;
    if (!RESET && tag_a_q[2]) begin
      rsp_valid_s[tag_a_q[1:0]]                 = 1'b1;
      rsp_data_s[int'(tag_a_q[1:0])*64 +: 64] = rddataA;
    end else begin
      rsp_valid_s = rsp_valid_s;
    end
    if (!RESET && tag_b_q[2]) begin
      rsp_valid_s[tag_b_q[1:0]]                 = 1'b1;
      rsp_data_s[int'(tag_b_q[1:0])*64 +: 64] = rddataB;
    end else begin
      rsp_valid_s = rsp_valid_s;
    end
  end

  assign cli.gnt      = gnt_s;
  assign cli.rspValid = rsp_valid_s;
  assign cli.rspData  = rsp_data_s;

endmodule

// File: tb/tb_uram_tdp_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uram_tdp_rr_arbiter
// Directed, table-driven bench for uram_tdp_rr_arbiter with a behavioural
// dual-port RAM model. Each table row is one clock cycle of inputs plus the
// hand-computed outputs expected in that same cycle.
// ---------------------------------------------------------------------------
module tb_uram_tdp_rr_arbiter;

  localparam int AW = 12;
  localparam int NR = 4;

  localparam logic [63:0] DB = 64'hDEADBEEF_00000001;
  localparam logic [63:0] D0 = 64'h01234567_89ABCDEF;

  typedef struct packed {
    logic             rst;
    logic [3:0]       req;
    logic [3:0]       wr;
    logic [3:0][11:0] addr;
    logic [3:0][63:0] wd;
    logic [3:0]       gnt;
    logic [3:0]       en;      // {wrenA, rdenA, wrenB, rdenB}
    logic [11:0]      addr_a;
    logic [11:0]      addr_b;
    logic [63:0]      wd_a;
    logic [63:0]      wd_b;
    logic [3:0]       rspv;
    logic [3:0][63:0] rsp;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  logic ram_init;
  logic wrenA, rdenA, wrenB, rdenB;
  logic [AW-1:0] wraddrsA, rdaddrsA, wraddrsB, rdaddrsB;
  logic [63:0] wrdataA, wrdataB, rddataA, rddataB;
  logic [63:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  vec_t vecs [15];

  uram_tdp_rr_arbiter_if #(.ADDRS_WIDTH(AW), .NREQ(NR)) bus ();

  uram_tdp_rr_arbiter #(.ADDRS_WIDTH(AW), .NREQ(NR)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .cli      (bus),
    .wrenA    (wrenA),
    .rdenA    (rdenA),
    .wrenB    (wrenB),
    .rdenB    (rdenB),
    .wraddrsA (wraddrsA),
    .rdaddrsA (rdaddrsA),
    .wraddrsB (wraddrsB),
    .rdaddrsB (rdaddrsB),
    .wrdataA  (wrdataA),
    .wrdataB  (wrdataB),
    .rddataA  (rddataA),
    .rddataB  (rddataB)
  );

  always #5 CLK = ~CLK;

  // Behavioural true-dual-port RAM: 1-cycle write, 1-cycle registered read.
  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 64'd0;
      mem[12'h040] <= 64'h55;
      mem[12'h100] <= 64'hA0;
      mem[12'h101] <= 64'hA1;
      mem[12'h102] <= 64'hA2;
      mem[12'h103] <= 64'hA3;
    end else begin
      if (wrenA) mem[wraddrsA] <= wrdataA;
      if (wrenB) mem[wraddrsB] <= wrdataB;
      if (rdenA) rddataA <= mem[rdaddrsA];
      if (rdenB) rddataB <= mem[rdaddrsB];
    end
  end

  function automatic vec_t mk(
    input logic rst, input logic [3:0] req, input logic [3:0] wr,
    input logic [3:0][11:0] addr, input logic [3:0][63:0] wd,
    input logic [3:0] gnt, input logic [3:0] en,
    input logic [11:0] aa, input logic [11:0] ab,
    input logic [63:0] wda, input logic [63:0] wdb,
    input logic [3:0] rv, input logic [3:0][63:0] rd);
    vec_t v;
    v.rst = rst; v.req = req; v.wr = wr; v.addr = addr; v.wd = wd;
    v.gnt = gnt; v.en = en; v.addr_a = aa; v.addr_b = ab;
    v.wd_a = wda; v.wd_b = wdb; v.rspv = rv; v.rsp = rd;
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] wr,
                       input logic [3:0][11:0] addr, input logic [3:0][63:0] wd);
    RESET         = rst;
    bus.req       = req;
    bus.reqWr     = wr;
    bus.reqAddrs  = addr;
    bus.reqWrdata = wd;
  endtask

  task automatic check_row(input int row, input vec_t v);
    chk("gnt",      row, 64'(bus.gnt), 64'(v.gnt));
    chk("enables",  row, 64'({wrenA, rdenA, wrenB, rdenB}), 64'(v.en));
    chk("wraddrsA", row, 64'(wraddrsA), 64'(v.addr_a));
    chk("rdaddrsA", row, 64'(rdaddrsA), 64'(v.addr_a));
    chk("wraddrsB", row, 64'(wraddrsB), 64'(v.addr_b));
    chk("rdaddrsB", row, 64'(rdaddrsB), 64'(v.addr_b));
    chk("wrdataA",  row, wrdataA, v.wd_a);
    chk("wrdataB",  row, wrdataB, v.wd_b);
    chk("rspValid", row, 64'(bus.rspValid), 64'(v.rspv));
    for (int i = 0; i < NR; i++)
      chk($sformatf("rspData[%0d]", i), row, bus.rspData[i*64 +: 64], v.rsp[i]);
  endtask

  logic [3:0][11:0] ad;
  logic [3:0][63:0] z;
  vec_t s;

  initial begin
    ad = {12'h103, 12'h102, 12'h101, 12'h100};
    z  = '0;
    //                rst   req    wr     addr  wd  gnt    en      addrA   addrB   wdA wdB  rspv   rsp
    vecs[0]  = mk(1'b1, 4'hF, 4'h0, ad, z, 4'h0, 4'b0000, 12'h000, 12'h000, 64'd0, 64'd0, 4'h0, z);
    vecs[1]  = mk(1'b1, 4'hF, 4'h0, ad, z, 4'h0, 4'b0000, 12'h000, 12'h000, 64'd0, 64'd0, 4'h0, z);
    vecs[2]  = mk(1'b0, 4'hF, 4'h0, ad, z, 4'h3, 4'b0101, 12'h100, 12'h101, 64'd0, 64'd0, 4'h0, z);
    vecs[3]  = mk(1'b0, 4'h4, 4'h4, {12'h103, 12'h010, 12'h101, 12'h100}, {64'd0, DB, 64'd0, 64'd0},
                  4'h4, 4'b1000, 12'h010, 12'h000, DB, 64'd0, 4'h3, {64'd0, 64'd0, 64'hA1, 64'hA0});
    vecs[4]  = mk(1'b0, 4'h8, 4'h0, {12'h010, 12'h102, 12'h101, 12'h100}, z,
                  4'h8, 4'b0100, 12'h010, 12'h000, 64'd0, 64'd0, 4'h0, z);
    vecs[5]  = mk(1'b0, 4'h7, 4'h1, {12'h103, 12'h030, 12'h020, 12'h020}, {64'd0, 64'd0, 64'd0, D0},
                  4'h5, 4'b1001, 12'h020, 12'h030, D0, 64'd0, 4'h8, {DB, 64'd0, 64'd0, 64'd0});
    vecs[6]  = mk(1'b0, 4'h2, 4'h0, {12'h103, 12'h030, 12'h020, 12'h020}, z,
                  4'h2, 4'b0100, 12'h020, 12'h000, 64'd0, 64'd0, 4'h4, z);
    vecs[7]  = mk(1'b0, 4'h1, 4'h0, {12'h103, 12'h102, 12'h101, 12'h050}, z,
                  4'h1, 4'b0100, 12'h050, 12'h000, 64'd0, 64'd0, 4'h2, {64'd0, 64'd0, D0, 64'd0});
    vecs[8]  = mk(1'b0, 4'hA, 4'h0, {12'h040, 12'h102, 12'h040, 12'h100}, z,
                  4'hA, 4'b0101, 12'h040, 12'h040, 64'd0, 64'd0, 4'h1, z);
    vecs[9]  = mk(1'b0, 4'h0, 4'h0, ad, z, 4'h0, 4'b0000, 12'h000, 12'h000, 64'd0, 64'd0, 4'hA,
                  {64'h55, 64'd0, 64'h55, 64'd0});
    vecs[10] = mk(1'b0, 4'hF, 4'h0, ad, z, 4'h3, 4'b0101, 12'h100, 12'h101, 64'd0, 64'd0, 4'h0, z);
    vecs[11] = mk(1'b0, 4'hF, 4'h0, ad, z, 4'hC, 4'b0101, 12'h102, 12'h103, 64'd0, 64'd0, 4'h3,
                  {64'd0, 64'd0, 64'hA1, 64'hA0});
    vecs[12] = mk(1'b0, 4'hF, 4'h0, ad, z, 4'h3, 4'b0101, 12'h100, 12'h101, 64'd0, 64'd0, 4'hC,
                  {64'hA3, 64'hA2, 64'd0, 64'd0});
    vecs[13] = mk(1'b0, 4'hF, 4'h0, ad, z, 4'hC, 4'b0101, 12'h102, 12'h103, 64'd0, 64'd0, 4'h3,
                  {64'd0, 64'd0, 64'hA1, 64'hA0});
    vecs[14] = mk(1'b0, 4'h0, 4'h0, ad, z, 4'h0, 4'b0000, 12'h000, 12'h000, 64'd0, 64'd0, 4'hC,
                  {64'hA3, 64'hA2, 64'd0, 64'd0});

    ram_init = 1'b1;
    drive(1'b1, 4'h0, 4'h0, ad, z);
    @(posedge CLK); #1;
    ram_init = 1'b0;

    for (int k = 0; k < 15; k++) begin
      drive(vecs[k].rst, vecs[k].req, vecs[k].wr, vecs[k].addr, vecs[k].wd);
      @(negedge CLK);
      check_row(k, vecs[k]);
      @(posedge CLK); #1;
    end

    // Reset in the return cycle of a read: response dropped, ptr back to 0.
    drive(1'b0, 4'h1, 4'h0, ad, z);
    @(negedge CLK);
    chk("midrst_gnt", 20, 64'(bus.gnt), 64'h1);
    chk("midrst_rdenA", 20, 64'(rdenA), 64'h1);
    @(posedge CLK); #1;
    drive(1'b1, 4'h0, 4'h0, ad, z);
    @(negedge CLK);
    chk("midrst_rspValid", 21, 64'(bus.rspValid), 64'h0);
    chk("midrst_rspData0", 21, bus.rspData[63:0], 64'd0);
    chk("midrst_gnt_in_reset", 21, 64'(bus.gnt), 64'h0);
    @(posedge CLK); #1;
    drive(1'b0, 4'hF, 4'h0, ad, z);
    @(negedge CLK);
    chk("post_rst_gnt", 22, 64'(bus.gnt), 64'h3);
    chk("post_rst_rspValid", 22, 64'(bus.rspValid), 64'h0);
    @(posedge CLK); #1;
    drive(1'b0, 4'h0, 4'h0, ad, z);
    @(negedge CLK);
    s = mk(1'b0, 4'h0, 4'h0, ad, z, 4'h0, 4'b0000, 12'h000, 12'h000, 64'd0, 64'd0, 4'h3,
           {64'd0, 64'd0, 64'hA1, 64'hA0});
    check_row(23, s);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uram_tdp_rr_arbiter.md
Name: uram_tdp_rr_arbiter

Overview:
- Shares one 64-bit true-dual-port ultraRAM (1-cycle write, 1-cycle read, independent A/B ports, separate wr/rd enable and address per port) between NREQ requesters.
- Sits between engine-side clients (e.g. spike/weight fetch units) and the RAM.
- Grants up to two requests per cycle, one on RAM port A and one on port B, in round-robin order.
- Blocks same-address hazards and routes read data back to the requester that issued the read.

Parameters:
- ADDRS_WIDTH, 12, RAM word-address width; must match the RAM instance.
- NREQ, 4, number of requesters; fixed at 4 for this revision, pointer is 2 bits.

Ports:
- CLK  in  1  system clock; all state on rising edge
- RESET  in  1  synchronous, active-high reset
- req  in  NREQ  request valid, one bit per requester; held until granted
- reqWr  in  NREQ  1 = write, 0 = read
- reqAddrs  in  NREQ*ADDRS_WIDTH  word address; requester i at slice [i*ADDRS_WIDTH +: ADDRS_WIDTH]
- reqWrdata  in  NREQ*64  write data; requester i at slice [i*64 +: 64]
- gnt  out  NREQ  combinational grant, same cycle as req
- rspValid  out  NREQ  registered; read data valid for requester i
- rspData  out  NREQ*64  read data for requester i; meaningful only while rspValid[i]
- wrenA, rdenA, wrenB, rdenB  out  1 each  RAM port enables
- wraddrsA, rdaddrsA, wraddrsB, rdaddrsB  out  ADDRS_WIDTH each  RAM port addresses
- wrdataA, wrdataB  out  64 each  RAM write data
- rddataA, rddataB  in  64 each  RAM read data, valid the cycle after rden

Behaviour:
- Reset: ptr=0; rspValid=0; tagA/tagB valid bits=0.
  - gnt and all RAM enables are 0 while RESET=1, regardless of req.
  - Requests pending during reset are neither granted nor lost; requesters keep req asserted.
- Port A pick:
  - First requester i with req[i]=1, scanning ptr, ptr+1, … mod NREQ.
- Port B pick:
  - First requester j≠A scanning circularly from A+1 with req[j]=1 and no conflict with A.
  - Conflict: reqAddrs[j]==reqAddrs[A] and (reqWr[j] or reqWr[A]).
  - Conflicting requester is skipped, not granted this cycle, and the scan continues.
  - Same-address read+read is allowed (both granted).
- Grant and port drive:
  - gnt[A]=1 and gnt[B]=1 when picked.
  - Winner on port A drives wrenA=reqWr, rdenA=~reqWr; both address outputs = its address; wrdataA = its data.
  - Port B is driven the same way from its winner.
  - Unused port: enables 0, addresses/data 0.
- Pointer update:
  - On any grant, ptr <= (last granted index, i.e. B if B granted else A) + 1 mod NREQ.
  - No grants: ptr holds.
- Read return:
  - On a read grant, register tagA/tagB = {valid, requester index}.
  - Next cycle, rspValid[tag] = 1 and rspData slice = rddataA or rddataB per port.
  - Read latency is exactly 1 cycle after gnt; one-cycle pulse; no backpressure.
  - A requester may re-request in the cycle after its grant (back-to-back throughput 1/cycle/requester).
- Write: complete at the grant edge. A read granted in any later cycle returns the new data.
- Reset mid-read: RESET=1 in the return cycle forces rspValid=0 and the read is dropped.
- rspData is a combinational mux from rddataA/B; it is 0 for any slice whose rspValid=0.

Test Plan:
- Reset:
  - RESET=1 with req=4'b1111 → gnt=0, wrenA/B=rdenA/B=0, rspValid=0.
  - Release → first cycle gnt=4'b0011 (A=0, B=1); ptr becomes 2.
- Write then read:
  - Requester 2 writes addr 0x010 data 0xDEADBEEF_00000001 → wrenA=1, wraddrsA=0x010.
  - Next cycle requester 3 reads 0x010 → rspValid[3]=1 one cycle later, rspData[3]=0xDEADBEEF_00000001.
- Hazard:
  - req0 write 0x020, req1 read 0x020, req2 read 0x030, ptr=0 → gnt=4'b0101.
  - Next cycle req1 granted, returns the written value.
- Same-address dual read:
  - req1 and req3 read 0x040 (preloaded 0x55), ptr=1 → gnt=4'b1010.
  - Next cycle rspValid=4'b1010, both slices = 0x55.
- Fairness:
  - All four hold reads for 4 cycles → grants 0011, 1100, 0011, 1100.
  - Each requester gets exactly 2 rspValid pulses.
- Reset mid-read:
  - Grant a read to requester 0, assert RESET the next cycle → rspValid stays 0; ptr=0 after release.
